// File: rtl/riscv_pkg.sv
// Shared RISC-V encoding constants and request bundle.
// Used by instr_pack and instr_assembler.
package riscv_pkg;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;
   localparam logic [2:0] IMM_R = 3'b101;

   localparam int XLEN  = 32;
   localparam int OPC_W = 7;
   localparam int REG_W = 5;
   localparam int F3_W  = 3;
   localparam int F7_W  = 7;

   typedef struct packed {
      logic [2:0]       imm_src;
      logic [XLEN-1:0]  imm;
      logic [OPC_W-1:0] opcode;
      logic [REG_W-1:0] rd;
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rs2;
      logic [F3_W-1:0]  funct3;
      logic [F7_W-1:0]  funct7;
   } req_t;

endpackage

// File: rtl/instr_pack.sv
// Combinational instruction packer with optional immediate range check.
// Build macro: IMM_RANGE_CHECK_EN enables the range check.
module instr_pack
   import riscv_pkg::*;
(
   input  req_t        req,
   output logic [31:0] instr,
   output logic        err
);

   logic bad_src;
   logic rng_bad;

   // place immediate and register fields per format
   always_comb begin
      instr   = '0;
      bad_src = 1'b0;
      case (req.imm_src)
         IMM_I: instr = {req.imm[11:0], req.rs1, req.funct3,
                         req.rd, req.opcode};
         IMM_S: instr = {req.imm[11:5], req.rs2, req.rs1,
                         req.funct3, req.imm[4:0], req.opcode};
         IMM_B: instr = {req.imm[12], req.imm[10:5], req.rs2,
                         req.rs1, req.funct3, req.imm[4:1],
                         req.imm[11], req.opcode};
         IMM_J: instr = {req.imm[20], req.imm[10:1], req.imm[11],
                         req.imm[19:12], req.rd, req.opcode};
         IMM_U: instr = {req.imm[31:12], req.rd, req.opcode};
         IMM_R: instr = {req.funct7, req.rs2, req.rs1,
                         req.funct3, req.rd, req.opcode};
         default: begin
            instr   = '0;
            bad_src = 1'b1;
         end
      endcase
   end

`ifdef IMM_RANGE_CHECK_EN
   // flag immediates whose dropped bits would be lost
   always_comb begin
      rng_bad = 1'b0;
      case (req.imm_src)
         IMM_I, IMM_S:
            rng_bad = !(&req.imm[31:11] || ~|req.imm[31:11]);
         IMM_B:
            rng_bad = !(&req.imm[31:12] || ~|req.imm[31:12])
                      || req.imm[0];
         IMM_J:
            rng_bad = !(&req.imm[31:20] || ~|req.imm[31:20])
                      || req.imm[0];
         IMM_U:
            rng_bad = |req.imm[11:0];
         default:
            rng_bad = 1'b0;
      endcase
   end
`else
   assign rng_bad = 1'b0;
`endif

   assign err = bad_src | rng_bad;

endmodule

// File: rtl/instr_assembler.sv
// Streaming instruction encoder with 2-entry output FIFO.
// Build macro: IMM_RANGE_CHECK_EN enables the immediate range check.
module instr_assembler
   import riscv_pkg::*;
#(
   parameter int COUNT_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2:0]         imm_src,
   input  logic [31:0]        imm,
   input  logic [6:0]         opcode,
   input  logic [4:0]         rd,
   input  logic [4:0]         rs1,
   input  logic [4:0]         rs2,
   input  logic [2:0]         funct3,
   input  logic [6:0]         funct7,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [31:0]        instr,
   output logic               err,
   output logic [COUNT_W-1:0] enc_count
);

   req_t        req;
   logic [31:0] pk_instr;
   logic        pk_err;
   logic [32:0] fifo_q [2];
   logic        rd_ptr;
   logic        wr_ptr;
   logic [1:0]  occ;
   logic        push;
   logic        pop;

   assign req = '{imm_src: imm_src, imm: imm, opcode: opcode,
                  rd: rd, rs1: rs1, rs2: rs2,
                  funct3: funct3, funct7: funct7};

   instr_pack u_pack (
      .req   (req),
      .instr (pk_instr),
      .err   (pk_err)
   );

   assign in_ready  = (occ != 2'd2);
   assign out_valid = (occ != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign {instr, err} = fifo_q[rd_ptr];

   // FIFO storage, pointers, occupancy and pop counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_q[0] <= '0;
         fifo_q[1] <= '0;
         rd_ptr    <= 1'b0;
         wr_ptr    <= 1'b0;
         occ       <= 2'd0;
         enc_count <= '0;
      end else begin
         if (push) begin
            fifo_q[wr_ptr] <= {pk_instr, pk_err};
            wr_ptr         <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr    <= ~rd_ptr;
            enc_count <= enc_count + 1'b1;
         end
         occ <= occ + 2'(push) - 2'(pop);
      end
   end

endmodule

// File: tb/tb_instr_assembler.sv
// Randomized self-checking bench for instr_assembler.
// Reference model encodes from field rules and decodes round-trip.
module tb_instr_assembler;
   import riscv_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        out_ready;
   logic [2:0]  imm_src;
   logic [31:0] imm;
   logic [6:0]  opcode;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3;
   logic [6:0]  funct7;

   logic        in_ready, out_valid, err;
   logic [31:0] instr;
   logic [15:0] enc_count;
   logic        in_ready2, out_valid2, err2;
   logic [31:0] instr2;
   logic [1:0]  enc_count2;

   int checks = 0;
   int errors = 0;
   int cnt    = 0;
   int pushes = 0;

   typedef struct {
      logic [31:0] instr;
      logic        err;
      logic [2:0]  src;
      logic [31:0] imm;
      bit          legal;
   } exp_t;

   exp_t q[$];

   always #5 clk = ~clk;

   instr_assembler #(.COUNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .imm_src(imm_src), .imm(imm), .opcode(opcode),
      .rd(rd), .rs1(rs1), .rs2(rs2),
      .funct3(funct3), .funct7(funct7),
      .out_valid(out_valid), .out_ready(out_ready),
      .instr(instr), .err(err), .enc_count(enc_count)
   );

   instr_assembler #(.COUNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready2),
      .imm_src(imm_src), .imm(imm), .opcode(opcode),
      .rd(rd), .rs1(rs1), .rs2(rs2),
      .funct3(funct3), .funct7(funct7),
      .out_valid(out_valid2), .out_ready(out_ready),
      .instr(instr2), .err(err2), .enc_count(enc_count2)
   );

   task automatic chk(string tag, logic [31:0] got,
                      logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit is_legal(logic [2:0] s,
                                   logic [31:0] v);
      int x;
      x = int'($signed(v));
      case (s)
         IMM_I, IMM_S: return x >= -2048 && x <= 2047;
         IMM_B: return x >= -4096 && x <= 4095 && x % 2 == 0;
         IMM_J: return x >= -(1 << 20) && x < (1 << 20)
                       && x % 2 == 0;
         IMM_U: return v % 4096 == 0;
         IMM_R: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic exp_t model();
      exp_t e;
      logic [31:0] regs, b;
      regs = (32'(rs2) << 20) | (32'(rs1) << 15)
           | (32'(funct3) << 12);
      e.src   = imm_src;
      e.imm   = imm;
      e.legal = is_legal(imm_src, imm);
      e.err   = 1'b0;
      b = 32'(opcode);
      case (imm_src)
         IMM_I: e.instr = ((imm & 32'hFFF) << 20)
                  | (32'(rs1) << 15) | (32'(funct3) << 12)
                  | (32'(rd) << 7) | b;
         IMM_S: e.instr = (((imm >> 5) & 32'h7F) << 25) | regs
                  | ((imm & 32'h1F) << 7) | b;
         IMM_B: e.instr = (((imm >> 12) & 1) << 31)
                  | (((imm >> 5) & 32'h3F) << 25) | regs
                  | (((imm >> 1) & 32'hF) << 8)
                  | (((imm >> 11) & 1) << 7) | b;
         IMM_J: e.instr = (((imm >> 20) & 1) << 31)
                  | (((imm >> 1) & 32'h3FF) << 21)
                  | (((imm >> 11) & 1) << 20)
                  | (((imm >> 12) & 32'hFF) << 12)
                  | (32'(rd) << 7) | b;
         IMM_U: e.instr = (imm & 32'hFFFFF000)
                  | (32'(rd) << 7) | b;
         IMM_R: e.instr = (32'(funct7) << 25) | regs
                  | (32'(rd) << 7) | b;
         default: begin
            e.instr = 32'h0;
            e.err   = 1'b1;
         end
      endcase
`ifdef IMM_RANGE_CHECK_EN
      if (!e.legal) e.err = 1'b1;
`endif
      return e;
   endfunction

   function automatic logic [31:0] ext_imm(logic [31:0] w,
                                           logic [2:0] s);
      case (s)
         IMM_I: return {{20{w[31]}}, w[31:20]};
         IMM_S: return {{20{w[31]}}, w[31:25], w[11:7]};
         IMM_B: return {{19{w[31]}}, w[31], w[7], w[30:25],
                        w[11:8], 1'b0};
         IMM_J: return {{11{w[31]}}, w[31], w[19:12], w[20],
                        w[30:21], 1'b0};
         IMM_U: return {w[31:12], 12'h000};
         default: return 32'h0;
      endcase
   endfunction

   task automatic rand_fields();
      int v;
      imm_src = 3'($urandom_range(0, 7));
      opcode  = 7'($urandom);
      rd      = 5'($urandom);
      rs1     = 5'($urandom);
      rs2     = 5'($urandom);
      funct3  = 3'($urandom);
      funct7  = 7'($urandom);
      if ($urandom_range(0, 1) == 0) begin
         imm = $urandom;
      end else begin
         case (imm_src)
            IMM_I, IMM_S: v = int'($urandom_range(0, 4095)) - 2048;
            IMM_B: v = (int'($urandom_range(0, 8191)) - 4096) & ~1;
            IMM_J: v = (int'($urandom_range(0, 2097151))
                        - 1048576) & ~1;
            default: v = int'($urandom & 32'hFFFFF000);
         endcase
         imm = 32'(v);
      end
   endtask

   task automatic set_req(logic [2:0] s, logic [31:0] v,
                          logic [6:0] op, logic [4:0] d,
                          logic [4:0] r1, logic [4:0] r2);
      imm_src = s; imm = v; opcode = op;
      rd = d; rs1 = r1; rs2 = r2;
      funct3 = 3'd0; funct7 = 7'd0;
   endtask

   // one clock: called at negedge with inputs already set
   task automatic cycle();
      bit   do_push, do_pop;
      exp_t e;
      do_push = in_valid && in_ready;
      do_pop  = out_valid && out_ready;
      if (do_pop) begin
         e = q.pop_front();
         chk("instr", instr, e.instr);
         chk("err", 32'(err), 32'(e.err));
         chk("instr2", instr2, e.instr);
         chk("err2", 32'(err2), 32'(e.err));
         if (e.legal && !e.err && e.src <= IMM_U)
            chk("roundtrip", ext_imm(instr, e.src), e.imm);
         cnt++;
      end
      if (do_push) begin
         q.push_back(model());
         pushes++;
      end
      @(posedge clk);
      @(negedge clk);
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
      chk("out_valid2", 32'(out_valid2), 32'(q.size() != 0));
      chk("in_ready2", 32'(in_ready2), 32'(q.size() < 2));
      chk("enc_count", 32'(enc_count), 32'(cnt % 65536));
      chk("enc_count2", 32'(enc_count2), 32'(cnt % 4));
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 10 && q.size() != 0; i++) cycle();
      chk("drain_empty", 32'(q.size()), 32'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      q.delete();
      cnt = 0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // push one directed request and check the packed word
   task automatic directed(string tag, logic [31:0] want,
                           logic want_err);
      in_valid  = 1'b1;
      out_ready = 1'b0;
      cycle();
      in_valid  = 1'b0;
      chk(tag, instr, want);
      chk({tag, "_err"}, 32'(err), 32'(want_err));
      out_ready = 1'b1;
      cycle();
   endtask

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      set_req(IMM_I, 32'h0, 7'h0, 5'd0, 5'd0, 5'd0);
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_instr", instr, 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_count", 32'(enc_count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      set_req(IMM_I, 32'hFFFFFFFF, 7'h13, 5'd1, 5'd2, 5'd0);
      directed("dir_i", 32'hFFF10093, 1'b0);
      set_req(IMM_B, 32'h00000FFE, 7'h63, 5'd0, 5'd3, 5'd4);
      directed("dir_b", 32'h7E418FE3, 1'b0);
      set_req(IMM_B, 32'h00001001, 7'h63, 5'd0, 5'd3, 5'd4);
`ifdef IMM_RANGE_CHECK_EN
      directed("dir_b_rng", model().instr, 1'b1);
`else
      directed("dir_b_rng", model().instr, 1'b0);
`endif
      set_req(IMM_U, 32'h12345000, 7'h37, 5'd5, 5'd0, 5'd0);
      directed("dir_u", 32'h123452B7, 1'b0);
      set_req(IMM_J, 32'hFFFFFFFC, 7'h6F, 5'd1, 5'd0, 5'd0);
      directed("dir_j", 32'hFFDFF0EF, 1'b0);
      chk("dir_j_rt", ext_imm(32'hFFDFF0EF, IMM_J), 32'hFFFFFFFC);
      set_req(3'b110, 32'h0, 7'h13, 5'd1, 5'd2, 5'd3);
      directed("dir_bad", 32'h0, 1'b1);

      // two entries buffered, then reset mid-stream
      in_valid  = 1'b1;
      out_ready = 1'b0;
      rand_fields(); cycle();
      rand_fields(); cycle();
      chk("mid_full", 32'(in_ready), 32'd0);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mid_out_valid", 32'(out_valid), 32'd0);
      chk("mid_count", 32'(enc_count), 32'd0);
      chk("mid_in_ready", 32'(in_ready), 32'd1);
      q.delete();
      cnt = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // backpressure: three pushes against a stalled consumer
      pushes    = 0;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      rand_fields();
      repeat (3) cycle();
      chk("bp_pushes", 32'(pushes), 32'd2);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      for (int i = 0; i < 10 && pushes < 3; i++) cycle();
      chk("bp_third", 32'(pushes), 32'd3);
      drain();
      chk("bp_count", 32'(enc_count), 32'd3);

      // counter wrap on the 2-bit instance
      do_reset();
      pushes    = 0;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 20 && pushes < 5; i++) begin
         rand_fields();
         cycle();
      end
      drain();
      chk("wrap_count2", 32'(enc_count2), 32'd1);
      chk("wrap_count", 32'(enc_count), 32'd5);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         rand_fields();
         cycle();
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
